match_offset_estimator: RTL
===========================

Name: match_offset_estimator

Overview:
- Sits between matcher and stitcher in the stereo stitching pipeline.
- Consumes matched keypoint pairs (left_keypoint / right_keypoint, strobed by matcher_valid) and rejects pairs with excessive vertical disparity.
- Accumulates the signed x/y displacement of the accepted pairs and, at end of frame, computes the mean translation with a sequential divider.
- Presents one registered offset result per frame to the stitcher.

Parameters:
- DY_TOL, 8, max |dy| in pixels for a pair to be accepted.
- DEFAULT_DX, 0, signed dx reported when no pair was accepted.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- match_valid  input  1  pair strobe, one pair per high cycle
- left_keypoint  input  32  [31:16]=row y, [15:0]=col x, unsigned
- right_keypoint  input  32  same format as left_keypoint
- match_done  input  1  end-of-frame pulse, one cycle
- offset_valid  output  1  one-cycle result strobe
- offset_dx  output  17  signed mean (left.x - right.x), held until next result
- offset_dy  output  17  signed mean (left.y - right.y), held until next result
- no_match  output  1  high with offset_valid when 0 pairs were accepted, held until next result
- pair_count  output  16  accepted pairs in the current accumulation
- busy  output  1  high in DIV_X, DIV_Y and DONE

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0; internal sums and count 0; state ACC.
- Per-pair arithmetic: dx = left.x - right.x and dy = left.y - right.y, both 17-bit signed.
- Acceptance: a pair is accepted if |dy| <= DY_TOL.
- Accumulators: sum_dx and sum_dy are 32-bit signed; count is 16-bit.
- States: ACC, DIV_X, DIV_Y, DONE.
- ACC:
  - Accepted pair on match_valid: sum_dx += dx, sum_dy += dy, count += 1 on the same edge.
  - count saturates at 65535; further pairs are ignored.
  - pair_count mirrors count.
- ACC with match_done:
  - If match_valid is high in the same cycle, that pair is accumulated before the division.
  - If the final count is 0: go to DONE; offset_dx = DEFAULT_DX, offset_dy = 0, no_match = 1.
  - Otherwise: go to DIV_X with no_match = 0.
- Division:
  - Restoring unsigned division of |sum| by count, one quotient bit per cycle.
  - 32 cycles in DIV_X, then 32 cycles in DIV_Y.
  - Sign is re-applied afterwards, so the result truncates toward zero.
  - Quotient is clipped to 17-bit signed, which cannot overflow given the input ranges.
- DONE: offset_valid = 1 for exactly one cycle; clear sums and count; return to ACC.
- Latency from the edge sampling match_done to offset_valid high:
  - count > 0: 66 edges.
  - count == 0: 1 edge.
- Inputs ignored while busy:
  - match_valid and match_done are ignored in DIV_X, DIV_Y and DONE.
  - Pairs arriving then are dropped, not queued.
- Output holding: offset_dx, offset_dy and no_match update only on the offset_valid cycle and hold otherwise.
- Reset mid-division: all state is cleared immediately; no offset_valid is produced for that frame.
- match_done with no prior pairs (back-to-back done pulses): each pulse yields its own no_match result, 1 edge later.

Test Plan:
- Basic mean: 3 pairs left (y,x)=(10,300),(20,310),(30,320) vs right (10,100),(21,110),(29,120), then match_done.
  - Required: offset_valid exactly 66 edges later; offset_dx = 200, offset_dy = 0 (sum 0/3); no_match = 0; pair_count 3 before done, 0 after.
- Outlier rejection: DY_TOL = 8; pairs with dy = 2, 9, -9, -8, all dx = 50.
  - Required: pair_count = 2; offset_dx = 50, offset_dy = -3 (-6/2).
- Truncation toward zero: 2 accepted pairs with dx = -3 and dx = -2.
  - Required: offset_dx = -2 (not -3); 2 pairs with dx = 3, 2 give +2.
- Empty frame: match_done with no pairs.
  - Required: offset_valid 1 edge later; offset_dx = DEFAULT_DX, offset_dy = 0, no_match = 1; busy high for exactly 1 cycle.
- Simultaneous and busy inputs:
  - match_valid with match_done in the same cycle (single pair dx = 7): result is 7.
  - match_valid pulses during DIV_X are dropped; the next frame's pair_count starts at 0.
- Reset mid-operation: assert rst_n = 0 at edge 20 of DIV_X.
  - Required: all outputs 0 immediately; no offset_valid; next frame of 1 pair (dx = 5) gives offset_dx = 5.

Source files
------------

// File: rtl/match_offset_estimator.sv
// match_offset_estimator
// Filters matched keypoint pairs by vertical disparity, accumulates the
// signed x/y displacement of the accepted pairs and, at end of frame,
// divides the sums by the pair count to report the mean translation.
// Uses restoring division, one quotient bit per cycle.
module match_offset_estimator #(
    parameter int unsigned        DY_TOL     = 8,
    parameter logic signed [16:0] DEFAULT_DX = 17'sd0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               match_valid,
    input  logic [31:0]        left_keypoint,
    input  logic [31:0]        right_keypoint,
    input  logic               match_done,
    output logic               offset_valid,
    output logic signed [16:0] offset_dx,
    output logic signed [16:0] offset_dy,
    output logic               no_match,
    output logic [15:0]        pair_count,
    output logic               busy
);

    localparam logic [1:0] ST_ACC   = 2'd0;
    localparam logic [1:0] ST_DIV_X = 2'd1;
    localparam logic [1:0] ST_DIV_Y = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [16:0] DY_TOL_V = 17'(DY_TOL);

    logic [1:0]         r_state;
    logic signed [31:0] r_sum_dx;
    logic signed [31:0] r_sum_dy;
    logic [15:0]        r_count;
    logic [5:0]         r_step;
    logic [31:0]        r_abs_y;
    logic               r_neg_x;
    logic               r_neg_y;
    logic [31:0]        r_rem;
    logic [31:0]        r_quo;
    logic signed [16:0] r_res_x;
    logic               r_offset_valid;
    logic signed [16:0] r_offset_dx;
    logic signed [16:0] r_offset_dy;
    logic               r_no_match;

    // Per-pair displacement: both coordinates are unsigned 16-bit, so a
    // zero-extended 17-bit subtraction cannot overflow.
    logic signed [16:0] w_dx;
    logic signed [16:0] w_dy;
    logic [16:0]        w_dy_abs;
    logic               w_accept;
    logic [31:0]        w_abs_sum_dx;
    logic [31:0]        w_abs_sum_dy;

    assign w_dx     = $signed({1'b0, left_keypoint[15:0]})  - $signed({1'b0, right_keypoint[15:0]});
    assign w_dy     = $signed({1'b0, left_keypoint[31:16]}) - $signed({1'b0, right_keypoint[31:16]});
    assign w_dy_abs = w_dy[16] ? unsigned'(-w_dy) : unsigned'(w_dy);
    // A saturated count freezes the sums too, keeping the mean consistent.
    assign w_accept = match_valid && (w_dy_abs <= DY_TOL_V) && (r_count != 16'hFFFF);

    assign w_abs_sum_dx = r_sum_dx[31] ? unsigned'(-r_sum_dx) : unsigned'(r_sum_dx);
    assign w_abs_sum_dy = r_sum_dy[31] ? unsigned'(-r_sum_dy) : unsigned'(r_sum_dy);

    // One restoring-division step. The partial remainder is always below the
    // count (< 2^16), so the 33-bit borrow is a reliable "fits" indicator.
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;

    assign w_shift    = {r_rem, r_quo[31]};
    assign w_diff     = w_shift - {17'd0, r_count};
    assign w_ge       = !w_diff[32];
    assign w_rem_next = w_ge ? w_diff[31:0] : w_shift[31:0];
    assign w_quo_next = {r_quo[30:0], w_ge};

    // Re-apply the sign to an unsigned quotient and clip to 17-bit signed.
    function automatic logic signed [16:0] apply_sign(input logic neg, input logic [31:0] mag);
        logic [16:0] m;
        if (mag > 32'd65535) m = neg ? 17'h10000 : 17'h0FFFF;
        else                 m = {1'b0, mag[15:0]};
        return neg ? -signed'(m) : signed'(m);
    endfunction

    // Accumulate in ACC, run the two divisions, publish the result in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_ACC;
            r_sum_dx       <= '0;
            r_sum_dy       <= '0;
            r_count        <= '0;
            r_step         <= '0;
            r_abs_y        <= '0;
            r_neg_x        <= 1'b0;
            r_neg_y        <= 1'b0;
            r_rem          <= '0;
            r_quo          <= '0;
            r_res_x        <= '0;
            r_offset_valid <= 1'b0;
            r_offset_dx    <= '0;
            r_offset_dy    <= '0;
            r_no_match     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments everywhere here, so every branch
            // reads the pre-edge register values regardless of statement order.
            r_offset_valid <= 1'b0;
            case (r_state)
                ST_ACC: begin
                    if (w_accept) begin
                        r_sum_dx <= r_sum_dx + 32'(w_dx);
                        r_sum_dy <= r_sum_dy + 32'(w_dy);
                        r_count  <= r_count + 16'd1;
                    end
                    if (match_done) begin
                        if (r_count == 16'd0 && !w_accept) begin
                            r_state        <= ST_DONE;
                            r_offset_valid <= 1'b1;
                            r_offset_dx    <= DEFAULT_DX;
                            r_offset_dy    <= '0;
                            r_no_match     <= 1'b1;
                        end else begin
                            r_state <= ST_DIV_X;
                            r_step  <= '0;
                        end
                    end
                end
                ST_DIV_X: begin
                    if (r_step == 6'd0) begin
                        // Operand-load cycle: registers the magnitudes of the
                        // final sums, including any pair taken with match_done.
                        r_quo   <= w_abs_sum_dx;
                        r_abs_y <= w_abs_sum_dy;
                        r_neg_x <= r_sum_dx[31];
                        r_neg_y <= r_sum_dy[31];
                        r_rem   <= '0;
                        r_step  <= 6'd1;
                    end else if (r_step == 6'd32) begin
                        r_res_x <= apply_sign(r_neg_x, w_quo_next);
                        r_quo   <= r_abs_y;
                        r_rem   <= '0;
                        r_step  <= 6'd1;
                        r_state <= ST_DIV_Y;
                    end else begin
                        r_rem  <= w_rem_next;
                        r_quo  <= w_quo_next;
                        r_step <= r_step + 6'd1;
                    end
                end
                ST_DIV_Y: begin
                    if (r_step == 6'd32) begin
                        r_offset_dx    <= r_res_x;
                        r_offset_dy    <= apply_sign(r_neg_y, w_quo_next);
                        r_no_match     <= 1'b0;
                        r_offset_valid <= 1'b1;
                        r_state        <= ST_DONE;
                    end else begin
                        r_rem  <= w_rem_next;
                        r_quo  <= w_quo_next;
                        r_step <= r_step + 6'd1;
                    end
                end
                default: begin
                    r_sum_dx <= '0;
                    r_sum_dy <= '0;
                    r_count  <= '0;
                    r_state  <= ST_ACC;
                end
            endcase
        end
    end

    assign offset_valid = r_offset_valid;
    assign offset_dx    = r_offset_dx;
    assign offset_dy    = r_offset_dy;
    assign no_match     = r_no_match;
    assign pair_count   = r_count;
    assign busy         = (r_state != ST_ACC);

endmodule
